// File: rtl/ysyx_24080018_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_24080018_pkg
//   Shared types and constants for the instruction fetch stage.
//   - fetch_state_e    : fetch FSM states (request / wait response / output)
//   - RESET_PC_DEFAULT : default PC loaded on reset
//   - INST_NOP         : canonical RV32 NOP (addi x0, x0, 0)
// ---------------------------------------------------------------------------
package ysyx_24080018_pkg;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

endpackage

// File: rtl/ysyx_24080018_fetch_reg.sv
// ---------------------------------------------------------------------------
// ysyx_24080018_fetch_reg
//   Generic enabled register with synchronous active-high reset.
//   Ports:
//     clk  in   clock
//     rst  in   synchronous reset, loads RESET_VAL
//     en   in   load enable
//     d    in   WIDTH  next value
//     q    out  WIDTH  registered value
// ---------------------------------------------------------------------------
module ysyx_24080018_fetch_reg #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/ysyx_24080018_fetch.sv
// ---------------------------------------------------------------------------
// ysyx_24080018_fetch
//   Instruction fetch stage of the single-issue RV32 core. Holds the PC,
//   issues one word fetch at a time to instruction memory, and hands the
//   returned word plus its PC to decode. Execute may redirect the PC at any
//   time; a fetch already in flight when that happens is dropped on return.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     mem_req_valid/ready/addr    fetch request channel (addr = pc)
//     mem_resp_valid/data/err     one-cycle response pulse, no backpressure
//     inst_valid/ready            handshake towards decode
//     inst, inst_pc, inst_err     fetched word, its PC, access-fault flag
//     redirect_valid, redirect_pc PC change from execute (low 2 bits ignored)
// ---------------------------------------------------------------------------
module ysyx_24080018_fetch
    import ysyx_24080018_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    output logic            mem_req_valid,
    input  logic            mem_req_ready,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_resp_valid,
    input  logic [XLEN-1:0] mem_resp_data,
    input  logic            mem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic            inst_err,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
);

    localparam int INST_W = 2 * XLEN + 1;

    fetch_state_e    state_reg, state_next;
    logic            discard_reg, discard_next;
    logic [XLEN-1:0] pc_reg, pc_next;
    logic            pc_en;
    logic            inst_en;
    logic            req_fire;
    logic [INST_W-1:0] inst_bundle_next, inst_bundle_reg;
    logic            redirect_lsb_unused;

    // Low PC bits from execute are deliberately dropped (word-aligned fetch).
    assign redirect_lsb_unused = ^redirect_pc[1:0];

    // Request is masked while reset is held so memory never sees a request
    // during a reset cycle, even if the FSM was sitting in S_REQ.
    assign mem_req_valid = (state_reg == S_REQ) && !rst;
    assign mem_req_addr  = pc_reg;
    assign req_fire      = mem_req_valid && mem_req_ready;
    assign inst_valid    = (state_reg == S_OUT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_REQ;
            discard_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            discard_reg <= discard_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        discard_next = discard_reg;
        pc_en        = 1'b0;
        pc_next      = pc_reg;
        inst_en      = 1'b0;

        case (state_reg)
            S_REQ: begin
                if (req_fire) begin
                    state_next   = S_WAIT;
                    // A redirect in the accept cycle makes this fetch stale.
                    discard_next = redirect_valid;
                end
            end
            S_WAIT: begin
                if (mem_resp_valid) begin
                    state_next   = S_REQ;
                    discard_next = 1'b0;
                    // A redirect landing with the response also kills it.
                    if (!discard_reg && !redirect_valid) begin
                        inst_en    = 1'b1;
                        state_next = S_OUT;
                    end
                end else if (redirect_valid) begin
                    discard_next = 1'b1;
                end
            end
            S_OUT: begin
                if (inst_ready) begin
                    pc_en      = 1'b1;
                    pc_next    = pc_reg + XLEN'(4);
                    state_next = S_REQ;
                end
                if (redirect_valid) begin
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase

        // Redirect overrides any sequential PC update.
        if (redirect_valid) begin
            pc_en   = 1'b1;
            pc_next = {redirect_pc[XLEN-1:2], 2'b00};
        end
    end

    ysyx_24080018_fetch_reg #(
        .WIDTH     (XLEN),
        .RESET_VAL (RESET_PC)
    ) u_pc_reg (
        .clk (clk),
        .rst (rst),
        .en  (pc_en),
        .d   (pc_next),
        .q   (pc_reg)
    );

    assign inst_bundle_next = {mem_resp_data, pc_reg, mem_resp_err};

    ysyx_24080018_fetch_reg #(
        .WIDTH     (INST_W),
        .RESET_VAL ('0)
    ) u_inst_reg (
        .clk (clk),
        .rst (rst),
        .en  (inst_en),
        .d   (inst_bundle_next),
        .q   (inst_bundle_reg)
    );

    assign inst     = inst_bundle_reg[INST_W-1 -: XLEN];
    assign inst_pc  = inst_bundle_reg[XLEN:1];
    assign inst_err = inst_bundle_reg[0];

    // Memory must only respond to an accepted, still-outstanding request.
    resp_only_in_wait: assert property (
        @(posedge clk) disable iff (rst) mem_resp_valid |-> (state_reg == S_WAIT)
    );

endmodule

// File: tb/tb_ysyx_24080018_fetch.sv
// ---------------------------------------------------------------------------
// tb_ysyx_24080018_fetch
//   Self-checking bench for the fetch stage: directed corner sequences, a
//   table of redirect-alignment vectors, a steady-throughput run and a
//   randomized run against a transaction-level PC/instruction model.
// ---------------------------------------------------------------------------
module tb_ysyx_24080018_fetch;
    import ysyx_24080018_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_resp_valid = 1'b0;
    logic [31:0] mem_resp_data = 32'h0;
    logic        mem_resp_err = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_err;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_24080018_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_addr   (mem_req_addr),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .mem_resp_err   (mem_resp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_err       (inst_err),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    typedef struct {
        logic [31:0] target;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[6];

    // Memory contents: a bit permutation of the address, so distinct per word.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]};
    endfunction

    function automatic logic err_fn(input logic [31:0] a);
        return (a[5:2] == 4'b1011);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From S_REQ: accept a request, return one response, leave DUT in S_OUT.
    task automatic fetch_to_out(input logic [31:0] data, input logic err);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = data;
        mem_resp_err   = err;
        step();
        mem_resp_valid = 1'b0;
        mem_resp_err   = 1'b0;
    endtask

    task automatic consume();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
    endtask

    // From S_REQ with memory stalled: move the PC without issuing a fetch.
    task automatic redirect_idle(input logic [31:0] target);
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = target;
        step();
        redirect_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] model_pc;
        logic [31:0] pend_addr;
        logic        pending;
        logic        prev_fire;
        int          due;
        int          delivered;
        int          tp_count;

        vecs[0] = '{32'h8000_0103, 32'h8000_0100};
        vecs[1] = '{32'h0000_0001, 32'h0000_0000};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC};
        vecs[3] = '{32'h1234_5676, 32'h1234_5674};
        vecs[4] = '{32'hA5A5_A5A8, 32'hA5A5_A5A8};
        vecs[5] = '{32'h8000_0002, 32'h8000_0000};

        // ---- 1: reset and first fetch latency ----
        step();
        step();
        chk("rst_req_valid", mem_req_valid, 0);
        chk("rst_inst_valid", inst_valid, 0);
        chk("rst_inst", inst, 0);
        chk("rst_inst_pc", inst_pc, 0);
        chk("rst_inst_err", inst_err, 0);
        chk("rst_addr", mem_req_addr, RESET_PC_DEFAULT);
        rst = 1'b0;
        mem_req_ready = 1'b1;
        #1;
        chk("t1_req_valid", mem_req_valid, 1);
        chk("t1_req_addr", mem_req_addr, 32'h8000_0000);
        step();
        mem_req_ready = 1'b0;
        chk("t1_wait_no_req", mem_req_valid, 0);
        chk("t1_wait_no_inst", inst_valid, 0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = INST_NOP;
        step();
        mem_resp_valid = 1'b0;
        chk("t1_inst_valid", inst_valid, 1);
        chk("t1_inst", inst, INST_NOP);
        chk("t1_inst_pc", inst_pc, 32'h8000_0000);
        chk("t1_inst_err", inst_err, 0);
        $display("test1 first fetch pc=%h inst=%h", inst_pc, inst);

        // ---- 2: decode stall holds the instruction ----
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t2_hold_valid", inst_valid, 1);
            chk("t2_hold_inst", inst, INST_NOP);
            chk("t2_hold_pc", inst_pc, 32'h8000_0000);
            chk("t2_no_req", mem_req_valid, 0);
        end
        consume();
        chk("t2_after_valid", inst_valid, 0);
        chk("t2_next_req", mem_req_valid, 1);
        chk("t2_next_addr", mem_req_addr, 32'h8000_0004);
        $display("test2 stall released next addr=%h", mem_req_addr);

        // ---- 3: redirect while waiting for response ----
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
        step();
        redirect_valid = 1'b0;
        chk("t3_wait_no_req", mem_req_valid, 0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h1111_1111;
        step();
        mem_resp_valid = 1'b0;
        chk("t3_dropped", inst_valid, 0);
        chk("t3_req_valid", mem_req_valid, 1);
        chk("t3_req_addr", mem_req_addr, 32'h8000_0100);
        step();
        chk("t3_still_dropped", inst_valid, 0);
        $display("test3 wait-redirect next addr=%h", mem_req_addr);

        // ---- 4: redirect coinciding with request handshake ----
        redirect_idle(32'h8000_0008);
        chk("t4_pre_addr", mem_req_addr, 32'h8000_0008);
        mem_req_ready  = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0200;
        step();
        mem_req_ready  = 1'b0;
        redirect_valid = 1'b0;
        chk("t4_in_wait", mem_req_valid, 0);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h2222_2222;
        step();
        mem_resp_valid = 1'b0;
        chk("t4_dropped", inst_valid, 0);
        chk("t4_req_addr", mem_req_addr, 32'h8000_0200);
        $display("test4 accept-redirect next addr=%h", mem_req_addr);

        // ---- 5: access fault travels with the instruction ----
        redirect_idle(32'h8000_0010);
        fetch_to_out(32'hDEAD_BEEF, 1'b1);
        chk("t5_valid", inst_valid, 1);
        chk("t5_err", inst_err, 1);
        chk("t5_pc", inst_pc, 32'h8000_0010);
        chk("t5_inst", inst, 32'hDEAD_BEEF);
        consume();
        chk("t5_next_addr", mem_req_addr, 32'h8000_0014);
        chk("t5_next_valid", mem_req_valid, 1);
        $display("test5 fault fetch next addr=%h", mem_req_addr);

        // ---- redirect in the same cycle as the response ----
        mem_req_ready = 1'b1;
        step();
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h3333_3333;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0300;
        step();
        mem_resp_valid = 1'b0;
        redirect_valid = 1'b0;
        chk("sc_dropped", inst_valid, 0);
        chk("sc_req_addr", mem_req_addr, 32'h8000_0300);
        step();
        chk("sc_stay_req", mem_req_valid, 1);
        fetch_to_out(32'h4444_4444, 1'b0);
        chk("sc_refetch_valid", inst_valid, 1);
        chk("sc_refetch_inst", inst, 32'h4444_4444);
        chk("sc_refetch_pc", inst_pc, 32'h8000_0300);
        $display("same-cycle redirect refetch pc=%h", inst_pc);

        // ---- redirect in S_OUT with and without same-cycle consume ----
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0400;
        step();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        chk("out_rdy_redir_valid", inst_valid, 0);
        chk("out_rdy_redir_addr", mem_req_addr, 32'h8000_0400);
        fetch_to_out(32'h5555_5555, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0500;
        step();
        redirect_valid = 1'b0;
        chk("out_redir_valid", inst_valid, 0);
        chk("out_redir_addr", mem_req_addr, 32'h8000_0500);
        $display("out-state redirects next addr=%h", mem_req_addr);

        // ---- 6: PC wrap and reset while waiting ----
        redirect_idle(32'hFFFF_FFFC);
        fetch_to_out(32'h6666_6666, 1'b0);
        chk("t6_pc_top", inst_pc, 32'hFFFF_FFFC);
        consume();
        chk("t6_wrap_addr", mem_req_addr, 32'h0000_0000);
        mem_req_ready = 1'b1;
        step();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        step();
        chk("t6_rst_req", mem_req_valid, 0);
        chk("t6_rst_inst_valid", inst_valid, 0);
        chk("t6_rst_addr", mem_req_addr, 32'h8000_0000);
        rst = 1'b0;
        #1;
        chk("t6_post_rst_req", mem_req_valid, 1);
        $display("test6 wrap and reset addr=%h", mem_req_addr);

        // ---- table: redirect target alignment ----
        for (int i = 0; i < 6; i++) begin
            redirect_idle(vecs[i].target);
            chk("tbl_req_valid", mem_req_valid, 1);
            chk("tbl_req_addr", mem_req_addr, vecs[i].exp_addr);
            $display("vector %0d target=%h addr=%h", i, vecs[i].target, mem_req_addr);
        end

        // ---- steady throughput: 1 instruction per 3 cycles ----
        redirect_idle(32'h8000_1000);
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        prev_fire     = 1'b0;
        tp_count      = 0;
        for (int c = 0; c < 30; c++) begin
            mem_resp_valid = prev_fire;
            mem_resp_data  = INST_NOP;
            prev_fire      = mem_req_valid && mem_req_ready;
            if (inst_valid) tp_count++;
            step();
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        inst_ready     = 1'b0;
        chk("throughput_30cyc", tp_count, 10);
        chk("throughput_end_addr", mem_req_addr, 32'h8000_1028);
        $display("throughput %0d instructions in 30 cycles", tp_count);

        // ---- randomized run against a transaction-level model ----
        redirect_idle(32'h8000_0000);
        model_pc  = 32'h8000_0000;
        pending   = 1'b0;
        pend_addr = 32'h0;
        due       = 0;
        delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            mem_resp_valid = 1'b0;
            if (pending && cyc >= due) begin
                mem_resp_valid = 1'b1;
                mem_resp_data  = mem_fn(pend_addr);
                mem_resp_err   = err_fn(pend_addr);
                pending        = 1'b0;
            end
            mem_req_ready  = 1'($urandom % 2);
            inst_ready     = 1'($urandom % 2);
            redirect_valid = (($urandom % 10) == 0);
            if (($urandom % 4) == 0) redirect_pc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
            else                     redirect_pc = 32'h8000_0000 | ($urandom & 32'hFFF);

            if (mem_req_valid) chk("rand_req_addr", mem_req_addr, model_pc);
            if (inst_valid && inst_ready) begin
                chk("rand_inst_pc", inst_pc, model_pc);
                chk("rand_inst", inst, mem_fn(model_pc));
                chk("rand_inst_err", inst_err, err_fn(model_pc));
                delivered++;
                model_pc = model_pc + 32'd4;
            end
            if (redirect_valid) model_pc = {redirect_pc[31:2], 2'b00};
            if (mem_req_valid && mem_req_ready) begin
                pending   = 1'b1;
                pend_addr = mem_req_addr;
                due       = cyc + 1 + int'($urandom % 3);
            end
            step();
        end
        mem_resp_valid = 1'b0;
        mem_req_ready  = 1'b0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        chk("rand_deliver_min", 32'(delivered >= 50), 1);
        $display("random run delivered %0d instructions", delivered);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
